// File: rtl/audio_seq.sv
// audio_seq: frame-synchronous 16-step note sequencer driving the PDM sample input.
// Each note sets a triangle-oscillator increment; a per-frame decaying envelope
// scales its amplitude.
// Optional feature macro: AUDIO_SEQ_LOOP_EN (wrap step 15 -> 0 instead of DONE).
module audio_seq #(
  parameter int unsigned TICKS_PER_STEP = 8,
  parameter int unsigned DECAY          = 16,
  parameter logic [63:0] PATTERN        = 64'h1357_9BDF_0864_2ACE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        run,
  input  logic        sample_strobe,
  output logic [15:0] sample,
  output logic [3:0]  step,
  output logic        busy,
  output logic        done
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned STEP_W   = 4;
  localparam int unsigned TICK_W   = 8;
  localparam int unsigned ENV_W    = 8;
  localparam int unsigned NOTE_W   = 4;
  localparam int unsigned PROD_W   = SAMPLE_W + ENV_W;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [ENV_W-1:0]  DECAY_V   = ENV_W'(DECAY);
  localparam logic [ENV_W-1:0]  ENV_FULL  = '1;
  localparam logic [STEP_W-1:0] STEP_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                vsync_q;
  logic                frame;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TICK_W-1:0]   tick_nxt;
  logic [SAMPLE_W-1:0] phase;
  logic [SAMPLE_W-1:0] phase_nxt;
  logic [SAMPLE_W-1:0] inc;
  logic [SAMPLE_W-1:0] inc_nxt;
  logic [ENV_W-1:0]    env;
  logic [ENV_W-1:0]    env_nxt;
  logic [STEP_W-1:0]   step_nxt;
  logic [STEP_W-1:0]   step_adv;
  logic [SAMPLE_W-1:0] sample_nxt;
  logic [SAMPLE_W-1:0] tri_wave;
  logic [PROD_W-1:0]   product;
  logic                busy_nxt;
  logic                done_nxt;

  // Note nibble for a given step index
  function automatic logic [NOTE_W-1:0] note_at(input logic [STEP_W-1:0] idx);
    note_at = PATTERN[{idx, 2'b00} +: NOTE_W];
  endfunction

  // Oscillator increment for a note: {note, 6'b0}
  function automatic logic [SAMPLE_W-1:0] inc_of(input logic [NOTE_W-1:0] note);
    inc_of = SAMPLE_W'({note, 6'b00_0000});
  endfunction

  // Envelope start level: full scale, or silent for a rest
  function automatic logic [ENV_W-1:0] env_of(input logic [NOTE_W-1:0] note);
    env_of = (note == '0) ? '0 : ENV_FULL;
  endfunction

  // Frame tick detection and oscillator shaping from the pre-add phase
  always_comb begin
    frame    = vsync & ~vsync_q;
    step_adv = step + STEP_W'(1);
    tri_wave = phase[15] ? {~phase[14:0], 1'b0} : {phase[14:0], 1'b0};
    product  = PROD_W'(tri_wave) * PROD_W'(env);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath next values
  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    step_nxt   = step;
    phase_nxt  = phase;
    inc_nxt    = inc;
    env_nxt    = env;
    sample_nxt = sample;

    case (state)
      IDLE: begin
        tick_nxt   = '0;
        step_nxt   = '0;
        phase_nxt  = '0;
        inc_nxt    = '0;
        env_nxt    = '0;
        sample_nxt = '0;
        if (run) begin
          state_nxt = PLAY;
          inc_nxt   = inc_of(note_at('0));
          env_nxt   = env_of(note_at('0));
        end
      end

      PLAY: begin
        if (!run) begin
          state_nxt  = IDLE;
          tick_nxt   = '0;
          step_nxt   = '0;
          phase_nxt  = '0;
          inc_nxt    = '0;
          env_nxt    = '0;
          sample_nxt = '0;
        end else begin
          // Strobe uses old phase/inc/env even when a frame lands in the same cycle
          if (sample_strobe) begin
            phase_nxt  = phase + inc;
            sample_nxt = product[PROD_W-1:ENV_W];
          end
          if (frame) begin
            if (tick_cnt < TICK_LAST) begin
              tick_nxt = tick_cnt + TICK_W'(1);
              env_nxt  = (env > DECAY_V) ? (env - DECAY_V) : '0;
            end else begin
              tick_nxt = '0;
              step_nxt = step_adv;
              inc_nxt  = inc_of(note_at(step_adv));
              env_nxt  = env_of(note_at(step_adv));
`ifndef AUDIO_SEQ_LOOP_EN
              if (step == STEP_LAST) begin
                state_nxt  = DONE;
                step_nxt   = step;
                sample_nxt = '0;
              end
`endif
            end
          end
        end
      end

      DONE: begin
        sample_nxt = '0;
        if (!run) begin
          state_nxt  = IDLE;
          tick_nxt   = '0;
          step_nxt   = '0;
          phase_nxt  = '0;
          inc_nxt    = '0;
          env_nxt    = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == PLAY);
    done_nxt = (state_nxt == DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      tick_cnt <= '0;
      step     <= '0;
      phase    <= '0;
      inc      <= '0;
      env      <= '0;
      sample   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      tick_cnt <= tick_nxt;
      step     <= step_nxt;
      phase    <= phase_nxt;
      inc      <= inc_nxt;
      env      <= env_nxt;
      sample   <= sample_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: doc/audio_seq.md
# audio_seq

Frame-synchronous step sequencer that drives the 16-bit sample input of the PDM audio modulator. It walks a 16-step note pattern, advancing one step every `TICKS_PER_STEP` video frames. Each note sets the increment of a phase-accumulator triangle oscillator, and a per-frame decaying envelope shapes its amplitude. It sits between the VGA sync generator (frame timing source) and the `pdm` block, and replaces the free-running triangle source.

## Interface

Parameters:
- `TICKS_PER_STEP`, default 8: frames per pattern step; legal range 1..255.
- `DECAY`, default 16: envelope decrement per frame; 8-bit.
- `PATTERN`, default 64'h1357_9BDF_0864_2ACE: note for step i is `PATTERN[4*i +: 4]`; note 0 is a rest.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `vsync`, input, 1: vsync from the sync generator, synchronous to `clk`; its rising edge is the frame tick.
- `run`, input, 1: level; 1 plays the pattern, 0 stops and clears.
- `sample_strobe`, input, 1: one-cycle pulse per audio sample period.
- `sample`, output, 16: unsigned sample to the PDM `pdm_in`.
- `step`, output, 4: index of the current step.
- `busy`, output, 1: high in PLAY.
- `done`, output, 1: high in DONE.

## Operation

- **Frame tick.** `vsync_q` is `vsync` registered. `frame = vsync & ~vsync_q`, a one-cycle pulse.
- **States.** IDLE, PLAY, DONE.
- **IDLE.**
  - Holds `step`=0, `tick_cnt`=0, `phase`=0, `env`=0, `sample`=0.
  - When `run`=1: go to PLAY next cycle, load `inc` from step 0, set `env`=255, or 0 if the note is 0.
- **PLAY, on `frame`, when `tick_cnt` < TICKS_PER_STEP-1:**
  - `tick_cnt`++.
  - `env` ← (`env` > DECAY) ? `env`-DECAY : 0.
- **PLAY, on `frame`, when `tick_cnt` == TICKS_PER_STEP-1:**
  - `tick_cnt` ← 0 and `step` ← `step`+1.
  - Load the new note: `inc` ← {note, 6'b0}.
  - `env` ← 255, or 0 for a rest; this replaces the decay for that frame.
- **End of pattern.**
  - Advancing past step 15 follows Configuration: wrap to step 0, or enter DONE.
- **PLAY, on `sample_strobe`:**
  - `phase` ← `phase` + `inc`, modulo 2^16.
  - `tri` = `phase[15]` ? {~`phase[14:0]`, 1'b0} : {`phase[14:0]`, 1'b0}, using the pre-add phase.
  - `sample` ← (`tri` × `env`) >> 8, a 24-bit product truncated to bits [23:8].
- **Simultaneous `frame` and `sample_strobe`.**
  - Both act in the same cycle.
  - The sample uses the old `env` and old `phase`.
  - The new `inc` first applies on the next strobe.
- **DONE.**
  - `sample`=0, `phase` frozen, `step`=15.
  - Go to IDLE when `run`=0.
- **`run` falls in PLAY.** Go to IDLE next cycle and clear all state; `sample` reads 0 one cycle after.
- **`sample` between strobes.** Holds its value.

## Timing

- **Reset.** `rst_n`=0 at a clk edge produces IDLE and clears all registers: `sample`=0, `step`=0, `busy`=0, `done`=0, `vsync_q`=0.
  - A mid-operation reset aborts immediately.
  - A vsync that is already high when reset releases yields a tick on the first cycle.
- **`run` rise to `busy`.** `busy`=1 on the edge following the first cycle `run`=1.
- **`frame` to `step`/`env`.** `step` and `env` update on the clk edge where `frame`=1; visible the next cycle.
- **`sample_strobe` to `sample`.** `sample` is valid one cycle after the strobe cycle.
- **Frames per step.** A step lasts exactly TICKS_PER_STEP frames. With TICKS_PER_STEP=1, every frame advances the step.
- **Strobe spacing.** Strobes are at least one cycle apart; back-to-back strobes are legal and each accumulates.

## Configuration

- `AUDIO_SEQ_LOOP_EN` defined:
  - Advancing from step 15 wraps to step 0, reloads the step-0 note and envelope, and stays in PLAY.
  - DONE is unreachable.
- `AUDIO_SEQ_LOOP_EN` undefined:
  - The advance from step 15 enters DONE on that edge.
  - `busy`=0 and `done`=1 the next cycle.

## Test plan

- **Reset.** Hold `rst_n`=0 for 3 cycles with `run`=1 -> `sample`=0, `step`=0, `busy`=0, `done`=0; PLAY entered 1 cycle after release.
- **Step advance.** TICKS_PER_STEP=8, with vsync pulses -> `step` reaches 1 after the 8th rising edge and 2 after the 16th.
- **Oscillator and envelope.**
  - Step 0 note 0xE gives `inc`=0x0380.
  - After 0x24 strobes, `phase`=0x7E00.
  - The next strobe with `env`=255 produces `sample`=(0xFC00×255)>>8=0xFB04.
- **Decay.** DECAY=16 and 3 frames into a step -> `env`=255-48=207; a rest note gives `sample`=0 after its next strobe.
- **Loop macro.** 128 frames with the macro defined -> `step` wraps 15 to 0 and `busy` stays 1. Without the macro -> `done`=1, `sample`=0, and IDLE after `run`=0.
- **Stop mid-step and coincident events.**
  - Drop `run` mid-step with `frame` and `sample_strobe` in the same cycle -> IDLE next cycle, `sample`=0.
  - Restart -> step 0 with `phase`=0.
